// File: rtl/scale_pixel_pick.sv
// Picks source pixels by index from a scaler's index stream and re-emits them as a scaled line.
// Handles upscale (repeat held pixel), downscale (skip pixels) and short-source edge replication.
module scale_pixel_pick #(
    parameter int C_PIXEL_WIDTH = 24,
    parameter int C_S_WIDTH     = 10,
    parameter int C_M_WIDTH     = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     i_valid,
    input  logic [C_S_WIDTH-1:0]     i_s_index,
    input  logic [C_M_WIDTH-1:0]     i_m_index,
    input  logic                     i_last,
    output logic                     i_ready,
    input  logic                     s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic                     err
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

    localparam logic [C_S_WIDTH-1:0] S_ONE = 1;
    localparam logic [C_M_WIDTH-1:0] M_ONE = 1;

    state_t                   state_q, state_d;
    logic [C_PIXEL_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [C_S_WIDTH-1:0]     hold_idx_q, hold_idx_d;
    logic                     hold_vld_q, hold_vld_d;
    logic [C_S_WIDTH-1:0]     src_cnt_q, src_cnt_d;
    logic                     src_done_q, src_done_d;
    logic [C_M_WIDTH-1:0]     ent_cnt_q, ent_cnt_d;
    logic                     m_valid_q, m_valid_d;
    logic [C_PIXEL_WIDTH-1:0] m_data_q, m_data_d;
    logic                     m_last_q, m_last_d;
    logic                     err_q, err_d;

    logic run, out_free, src_ok, s_acc, byp, hold_hit, hold_rep, consume;

    assign run      = (state_q == ST_RUN);
    assign out_free = !m_valid_q || m_axis_tready;
    // A source pixel may replace the hold register only when the held one is no longer wanted.
    assign src_ok   = run && !src_done_q && (!hold_vld_q || (i_valid && (hold_idx_q < i_s_index)));
    assign s_acc    = src_ok && s_axis_tvalid;
    // Bypass: the pixel arriving now is exactly the one requested, so emit it while it is loaded.
    assign byp      = s_acc && i_valid && (src_cnt_q == i_s_index);
    assign hold_hit = hold_vld_q && i_valid && (hold_idx_q == i_s_index);
    assign hold_rep = hold_vld_q && i_valid &&
                      ((hold_idx_q > i_s_index) || (src_done_q && (hold_idx_q < i_s_index)));
    assign consume  = run && out_free && (hold_hit || hold_rep || byp);

    assign i_ready       = !reset && consume;
    assign s_axis_tready = !reset && ((state_q == ST_DRAIN) || src_ok);
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tlast  = m_last_q;
    assign err           = err_q;

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_idx_d  = hold_idx_q;
        hold_vld_d  = hold_vld_q;
        src_cnt_d   = src_cnt_q;
        src_done_d  = src_done_q;
        ent_cnt_d   = ent_cnt_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_last_d    = m_last_q;
        err_d       = err_q;

        if (s_acc) begin
            hold_data_d = s_axis_tdata;
            hold_idx_d  = src_cnt_q;
            hold_vld_d  = 1'b1;
            src_cnt_d   = src_cnt_q + S_ONE;
            if (s_axis_tlast) begin
                src_done_d = 1'b1;
            end
        end

        if (consume) begin
            m_valid_d = 1'b1;
            m_data_d  = byp ? s_axis_tdata : hold_data_q;
            m_last_d  = i_last;
            ent_cnt_d = ent_cnt_q + M_ONE;
            if (hold_rep || (i_m_index != ent_cnt_q)) begin
                err_d = 1'b1;
            end
            if (i_last) begin
                state_d = (src_done_q || (s_acc && s_axis_tlast)) ? ST_IDLE : ST_DRAIN;
            end
        end else if (m_axis_tready) begin
            m_valid_d = 1'b0;
        end

        if ((state_q == ST_DRAIN) && s_axis_tvalid && s_axis_tlast) begin
            state_d = ST_IDLE;
        end

        // start wins over any handshake in the same cycle and drops a pending output beat
        if (start) begin
            state_d    = ST_RUN;
            hold_vld_d = 1'b0;
            src_cnt_d  = '0;
            src_done_d = 1'b0;
            ent_cnt_d  = '0;
            m_valid_d  = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_data_q <= '0;
            hold_idx_q  <= '0;
            hold_vld_q  <= 1'b0;
            src_cnt_q   <= '0;
            src_done_q  <= 1'b0;
            ent_cnt_q   <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_idx_q  <= hold_idx_d;
            hold_vld_q  <= hold_vld_d;
            src_cnt_q   <= src_cnt_d;
            src_done_q  <= src_done_d;
            ent_cnt_q   <= ent_cnt_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_last_q    <= m_last_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: doc/scale_pixel_pick.md
SCALE_PIXEL_PICK -- requirements
Module: scale_pixel_pick

Interface
REQ-001 SHALL have parameter C_PIXEL_WIDTH, default 24, the pixel data width.
REQ-002 SHALL have parameter C_S_WIDTH, default 10, the source index width.
REQ-003 SHALL have parameter C_M_WIDTH, default 12, the output index width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse that arms a new line.
REQ-007 SHALL have port i_valid  input  1  index entry valid (scaler output).
REQ-008 SHALL have port i_s_index  input  C_S_WIDTH  source pixel index to emit.
REQ-009 SHALL have port i_m_index  input  C_M_WIDTH  output pixel index (informational, checked only).
REQ-010 SHALL have port i_last  input  1  final index entry of the line.
REQ-011 SHALL have port i_ready  output  1  index entry accepted when i_valid && i_ready.
REQ-012 SHALL have port s_axis_tvalid / s_axis_tdata / s_axis_tlast  input  1 / C_PIXEL_WIDTH / 1  source pixel stream, one line per frame-line.
REQ-013 SHALL have port s_axis_tready  output  1  source pixel accepted.
REQ-014 SHALL have port m_axis_tvalid / m_axis_tdata / m_axis_tlast  output  1 / C_PIXEL_WIDTH / 1  scaled pixel stream.
REQ-015 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-016 SHALL have port err  output  1  sticky error flag, cleared by start.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN; start from any state SHALL enter RUN, abandoning any line in progress.
REQ-018 In RUN, SHALL hold one source pixel register (hold_data, hold_idx, hold_vld); hold_vld cleared and next source index set to 0 on start.
REQ-019 Every accepted source pixel SHALL load the hold register with index equal to the count of source pixels accepted since start (width C_S_WIDTH, wraps modulo 2^C_S_WIDTH).
REQ-020 s_axis_tready SHALL be high in RUN only when !hold_vld, or hold_idx < i_s_index with i_valid high, or an index entry is being consumed this cycle and the source register is free; s_axis_tready SHALL be high throughout DRAIN and low in IDLE.
REQ-021 An index entry SHALL be consumed (i_ready high) when i_valid, hold_vld, hold_idx == i_s_index and the output register is empty or m_axis_tready is high.
REQ-022 On consumption, m_axis_tdata SHALL take hold_data and m_axis_tlast SHALL take i_last, with m_axis_tvalid asserted the next cycle (latency 1 cycle from consumption).
REQ-023 m_axis_tvalid/tdata/tlast SHALL remain stable while m_axis_tvalid && !m_axis_tready.
REQ-024 Sustained throughput SHALL be one output pixel per cycle, both when repeating a held pixel (upscale) and when each entry needs one new source pixel.
REQ-025 Source pixels with index below the requested i_s_index SHALL be accepted and discarded without output.
REQ-026 After the i_last entry is consumed: if the source tlast has already been accepted, SHALL go to IDLE; otherwise SHALL go to DRAIN, discarding source pixels until tlast is accepted, then IDLE.
REQ-027 If the source tlast is accepted while hold_idx < the pending i_s_index, SHALL set err and emit hold_data for every remaining index entry (edge replication).
REQ-028 If i_s_index is less than hold_idx (non-monotonic), SHALL set err and emit hold_data.
REQ-029 If i_m_index does not equal the count of entries consumed since start, SHALL set err; output is unaffected.
REQ-030 i_valid or s_axis_tvalid in IDLE SHALL be ignored (i_ready and s_axis_tready low).
REQ-031 start coinciding with a handshake SHALL take priority: that handshake's data is discarded, and a pending m_axis beat SHALL be dropped (m_axis_tvalid low next cycle).

Reset
REQ-032 While reset is high, state SHALL be IDLE and i_ready, s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, err, hold_vld and all counters SHALL be 0; reset overrides start.
REQ-033 Reset asserted mid-line SHALL abort without emitting further beats; the next line SHALL need a new start.

Verification
REQ-034 Upscale: start, source P0..P3 (tlast on P3), indices 0,0,1,1,2,2,3,3 (i_last on 8th), all ready high -> output P0,P0,P1,P1,P2,P2,P3,P3 on 8 consecutive cycles, tlast on 8th only, err=0, then IDLE.
REQ-035 Downscale: source P0..P7, indices 1,3,5,7 -> output P1,P3,P5,P7, tlast on P7; all 8 source beats accepted; err=0.
REQ-036 Early tail: source P0..P3, indices 0,2,4,6 -> output P0,P2,P3,P3, err=1 after P3 tlast accepted.
REQ-037 Backpressure: REQ-034 stimulus with m_axis_tready toggling 1,0,0,1 -> identical data sequence, no beat lost or duplicated, data stable while stalled.
REQ-038 Reset mid-line: reset for 1 cycle after 3 output beats -> all outputs 0 next cycle, no further beats until new start; next line correct.
REQ-039 Restart: start while DRAIN with 2 source pixels outstanding -> new line begins at source index 0, err cleared.
